// File: rtl/fire6_expand1_writeback.sv
// fire6 expand1x1 drain stage: snapshots each pixel's channel results and
// serialises them into a channel-group-major banked feature-map RAM write stream.
module fire6_expand1_writeback #(
    parameter int unsigned DSP_NO = 256,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned WOUT   = 16,
    parameter int unsigned BANKS  = 8,
    localparam int unsigned G     = DSP_NO / BANKS,
    localparam int unsigned NPIX  = WOUT * WOUT,
    localparam int unsigned AW    = $clog2(G * NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_i,
    input  logic [WIDTH-1:0] ofm_i [0:DSP_NO-1],
    output logic             wr_en_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o [0:BANKS-1],
    output logic             busy_o,
    output logic             overrun_o,
    output logic             ram_feedback_o,
    output logic             done_o
);

    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned PW = $clog2(NPIX + 1);
    localparam int unsigned CW = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grp_q, grp_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic [WIDTH-1:0] snap_q [0:DSP_NO-1];
    logic [WIDTH-1:0] snap_d [0:DSP_NO-1];
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q [0:BANKS-1];
    logic [WIDTH-1:0] wr_data_d [0:BANKS-1];
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             fb_q, fb_d;
    logic             done_q, done_d;
    logic             capture;

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        pix_d     = pix_q;
        snap_d    = snap_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        overrun_d = overrun_q;
        capture   = 1'b0;
        // done rises with the feedback pulse, one cycle after the final beat
        done_d    = (state_q == DONE);
        fb_d      = (state_q == DONE) && !done_q;

        case (state_q)
            IDLE: begin
                if (sample_i) begin
                    capture = 1'b1;
                    grp_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wr_en_d   = 1'b1;
                busy_d    = 1'b1;
                wr_addr_d = AW'(grp_q) * AW'(NPIX) + AW'(pix_q);
                for (int unsigned b = 0; b < BANKS; b++) begin
                    wr_data_d[b] = snap_q[CW'(grp_q * BANKS + b)];
                end
                if (grp_q == GRP_LAST) begin
                    pix_d = pix_q + PW'(1);
                    if (pix_q == PIX_LAST) begin
                        state_d = DONE;
                    end else if (sample_i) begin
                        capture = 1'b1;
                        grp_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    grp_d = grp_q + GW'(1);
                    if (sample_i) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            snap_d = ofm_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grp_q     <= '0;
            pix_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            fb_q      <= 1'b0;
            done_q    <= 1'b0;
            for (int unsigned c = 0; c < DSP_NO; c++) begin
                snap_q[c] <= '0;
            end
            for (int unsigned b = 0; b < BANKS; b++) begin
                wr_data_q[b] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            pix_q     <= pix_d;
            snap_q    <= snap_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            fb_q      <= fb_d;
            done_q    <= done_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;
    assign ram_feedback_o = fb_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_fire6_expand1_writeback.sv
// Scoreboard bench for fire6_expand1_writeback: stimulus pushes expected write
// beats, a negedge monitor pops and compares every beat the DUT emits.
module tb_fire6_expand1_writeback;

    localparam int unsigned DSP_NO = 256;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned WOUT   = 16;
    localparam int unsigned BANKS  = 8;
    localparam int unsigned G      = DSP_NO / BANKS;
    localparam int unsigned NPIX   = WOUT * WOUT;
    localparam int unsigned AW     = 13;
    localparam int unsigned LW     = BANKS * WIDTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_i;
    logic [WIDTH-1:0] ofm_v [0:DSP_NO-1];
    logic             wr_en_o;
    logic [AW-1:0]    wr_addr_o;
    logic [WIDTH-1:0] wr_data [0:BANKS-1];
    logic             busy_o;
    logic             overrun_o;
    logic             ram_feedback_o;
    logic             done_o;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beat_cnt = 0;
    int    busy_cnt = 0;
    int    fb_cnt   = 0;
    int    exp_pix  = 0;
    int    written [0:G*NPIX-1];
    logic          prev_wr   = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    fire6_expand1_writeback #(
        .DSP_NO(DSP_NO),
        .WIDTH (WIDTH),
        .WOUT  (WOUT),
        .BANKS (BANKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_i      (sample_i),
        .ofm_i         (ofm_v),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .ram_feedback_o(ram_feedback_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_out();
        logic [LW-1:0] v;
        v = '0;
        for (int b = 0; b < BANKS; b++) v[b*WIDTH +: WIDTH] = wr_data[b];
        return v;
    endfunction

    // Monitor: every emitted beat is checked against the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (ram_feedback_o) begin
                fb_cnt++;
                chk("fb_after_last_beat", LW'({prev_wr, prev_addr}), LW'({1'b1, 13'd8191}));
                chk("done_with_fb", LW'(done_o), LW'(1));
            end
            if (wr_en_o) begin
                beat_t e;
                beat_cnt++;
                written[wr_addr_o]++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", LW'(wr_addr_o), '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", LW'(wr_addr_o), LW'(e.addr));
                    chk("beat_data", pack_out(), e.data);
                end
            end
            if (busy_o) busy_cnt++;
            prev_wr   = wr_en_o;
            prev_addr = wr_addr_o;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic load_pat(input logic [WIDTH-1:0] base, input bit use_xor);
        for (int c = 0; c < DSP_NO; c++)
            ofm_v[c] = use_xor ? (base ^ WIDTH'(c)) : (base + WIDTH'(c));
    endtask

    task automatic load_rand();
        for (int c = 0; c < DSP_NO; c++) ofm_v[c] = WIDTH'($urandom);
    endtask

    // Sample is seen at the posedge this task returns just after.
    task automatic pulse(input bit accept);
        beat_t e;
        @(posedge clk) #1;
        sample_i = 1'b1;
        if (accept) begin
            for (int g = 0; g < G; g++) begin
                e.addr = AW'(g * NPIX + exp_pix);
                for (int b = 0; b < BANKS; b++) e.data[b*WIDTH +: WIDTH] = ofm_v[g*BANKS + b];
                exp_q.push_back(e);
            end
            exp_pix++;
        end
        @(posedge clk) #1;
        sample_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 400) begin
            @(negedge clk) #1;
            n++;
        end
        chk("drain_complete", LW'(exp_q.size()), '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   LW'(wr_en_o), '0);
        chk({tag, "_wr_addr"}, LW'(wr_addr_o), '0);
        chk({tag, "_wr_data"}, pack_out(), '0);
        chk({tag, "_busy"},    LW'(busy_o), '0);
        chk({tag, "_overrun"}, LW'(overrun_o), '0);
        chk({tag, "_fb"},      LW'(ram_feedback_o), '0);
        chk({tag, "_done"},    LW'(done_o), '0);
    endtask

    initial begin
        int base;
        int bad;
        rst      = 1'b0;
        sample_i = 1'b0;
        for (int c = 0; c < DSP_NO; c++) ofm_v[c] = '0;
        for (int a = 0; a < G*NPIX; a++) written[a] = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel: lane b of beat g carries 8g+b, busy for 32 cycles
        load_pat(16'h0000, 1'b0);
        busy_cnt = 0;
        pulse(1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("first_beat_latency", LW'(wr_en_o), LW'(1));
        wait_drain();
        chk("single_busy_cycles", LW'(busy_cnt), LW'(32));

        // Back-to-back: second sample coincides with the last beat
        load_pat(16'hA000, 1'b0);
        pulse(1'b1);
        repeat (30) @(posedge clk);
        load_pat(16'hB000, 1'b1);
        pulse(1'b1);
        @(negedge clk);
        chk("b2b_last_beat_present", LW'(wr_en_o), LW'(1));
        @(negedge clk);
        chk("b2b_no_gap", LW'(wr_en_o), LW'(1));
        wait_drain();
        chk("b2b_no_overrun", LW'(overrun_o), '0);

        // Overrun: sample at beat 10 is dropped, original data drains
        load_pat(16'hC000, 1'b0);
        pulse(1'b1);
        repeat (9) @(posedge clk);
        load_pat(16'hFFFF, 1'b0);
        pulse(1'b0);
        chk("overrun_set", LW'(overrun_o), LW'(1));
        wait_drain();
        chk("overrun_sticky", LW'(overrun_o), LW'(1));

        // Reset during beat 5 of the next pixel (pix 4)
        load_pat(16'h5000, 1'b1);
        base = beat_cnt;
        pulse(1'b1);
        for (int n = 0; n < 100 && beat_cnt < base + 6; n++) begin
            @(negedge clk) #1;
        end
        chk("reset_reached_beat5", LW'(beat_cnt - base), LW'(6));
        #1 rst = 1'b0;
        #1 chk_all_zero("mid_reset");
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        exp_pix = 0;
        load_pat(16'h6000, 1'b0);
        pulse(1'b1);
        wait_drain();

        // Full map with random pixels at 65-cycle spacing
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        for (int a = 0; a < G*NPIX; a++) written[a] = 0;
        exp_pix = 0;
        fb_cnt  = 0;
        @(negedge clk) rst = 1'b1;
        base = beat_cnt;
        for (int p = 0; p < NPIX; p++) begin
            load_rand();
            pulse(1'b1);
            repeat (63) @(posedge clk);
        end
        wait_drain();
        chk("map_write_count", LW'(beat_cnt - base), LW'(G*NPIX));
        bad = 0;
        for (int a = 0; a < G*NPIX; a++) if (written[a] != 1) bad++;
        chk("map_every_addr_once", LW'(bad), '0);
        chk("map_fb_pulse_count", LW'(fb_cnt), LW'(1));
        chk("map_done", LW'(done_o), LW'(1));
        chk("map_no_overrun", LW'(overrun_o), '0);

        // After done: samples are ignored silently
        base = beat_cnt;
        load_rand();
        pulse(1'b0);
        repeat (40) @(negedge clk);
        chk("done_no_writes", LW'(beat_cnt - base), '0);
        chk("done_no_overrun", LW'(overrun_o), '0);
        chk("done_sticky", LW'(done_o), LW'(1));
        chk("done_fb_once", LW'(fb_cnt), LW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
